// File: rtl/adc_bitserial_accumulator_if.sv
// ---------------------------------------------------------------------------
// adc_bitserial_accumulator_if
//
// Purpose: groups the two streaming handshakes of the bit-serial accumulator.
//   - ADC side: one bit-plane of signed ADC results per beat.
//   - Output side: one full-precision per-column sum per beat.
//
// Handshake rule (both channels): a beat transfers on the rising clock edge
// where valid and ready are both high. Once the producer raises valid, it
// holds valid and data stable until that transfer. Ready may change freely
// and never depends combinationally on valid.
//
// Signal names carry the direction as seen from the accumulator.
//   master : the accumulator (drives adc_ready_o, out_valid_o, out_data_o)
//   slave  : the environment (ADC wrapper + output buffer)
//
// Signals:
//   adc_valid_i  adc_data_i holds one bit-plane result
//   adc_ready_o  accumulator accepts a bit-plane
//   adc_data_i   [numCols-1:0][numAdcBits-1:0] signed ADC results
//   out_valid_o  out_data_o holds a completed sum
//   out_ready_i  consumer accepts the sum
//   out_data_o   [numCols-1:0][numAccBits-1:0] signed sums
// ---------------------------------------------------------------------------
interface adc_bitserial_accumulator_if #(
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int numAccBits = 12
);
  logic                                 adc_valid_i;
  logic                                 adc_ready_o;
  logic [numCols-1:0][numAdcBits-1:0]   adc_data_i;
  logic                                 out_valid_o;
  logic                                 out_ready_i;
  logic [numCols-1:0][numAccBits-1:0]   out_data_o;

  modport master (
    input  adc_valid_i,
    input  adc_data_i,
    output adc_ready_o,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o
  );

  modport slave (
    output adc_valid_i,
    output adc_data_i,
    input  adc_ready_o,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o
  );
endinterface

// File: rtl/adc_bitserial_accumulator.sv
// ---------------------------------------------------------------------------
// adc_bitserial_accumulator
//
// Purpose: shift-adds per-bit-plane signed ADC results (activations applied
// LSB first, one plane per beat) into full-precision signed per-column
// partial sums, then presents the sums over a valid/ready handshake.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   start_i       begin a new accumulation; config captured on acceptance
//   cfg_n_bits_i  activation precision (0 -> 1, >maxInBits -> maxInBits)
//   cfg_signed_i  1 = MSB plane carries negative weight
//   busy_o        high whenever the FSM is not IDLE
//   dbg_state_o   current FSM state (0 IDLE, 1 ACCUM, 2 OUTPUT)
//   bus           ADC input stream and sum output stream (master modport)
// ---------------------------------------------------------------------------
module adc_bitserial_accumulator #(
  parameter int numCols    = 32,
  parameter int numAdcBits = 4,
  parameter int maxInBits  = 8,
  parameter int numAccBits = numAdcBits + maxInBits
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [$clog2(maxInBits+1)-1:0]     cfg_n_bits_i,
  input  logic                               cfg_signed_i,
  output logic                               busy_o,
  output logic [1:0]                         dbg_state_o,
  adc_bitserial_accumulator_if.master        bus
);

  localparam int CNW = $clog2(maxInBits + 1);
  localparam logic [CNW-1:0] MAX_N = CNW'(maxInBits);
  localparam logic [CNW-1:0] ONE_N = CNW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                              r_state;
  state_t                              w_state_next;
  logic [CNW-1:0]                      r_n;
  logic                                r_signed;
  logic [CNW-1:0]                      r_bit_cnt;
  logic [numCols-1:0][numAccBits-1:0]  r_acc;

  logic [numCols-1:0][numAccBits-1:0]  w_acc_next;
  logic [numAccBits-1:0]               w_term;
  logic [CNW-1:0]                      w_n_clamped;
  logic                                w_beat;
  logic                                w_last;
  logic                                w_sub;
  logic                                w_out_fire;
  logic                                w_load;
  logic                                w_busy;
  logic                                w_adc_ready;
  logic                                w_out_valid;

  // Illegal precisions are folded into the legal range at capture time.
  assign w_n_clamped = (cfg_n_bits_i == '0)   ? ONE_N :
                       (cfg_n_bits_i > MAX_N) ? MAX_N : cfg_n_bits_i;

  assign w_beat     = (r_state == ACCUM) && bus.adc_valid_i;
  assign w_last     = (r_bit_cnt == (r_n - ONE_N));
  assign w_sub      = r_signed && w_last;
  assign w_out_fire = (r_state == OUTPUT) && bus.out_ready_i;
  // A new job starts either from IDLE or on the output handshake itself,
  // which gives zero-bubble back-to-back operation.
  assign w_load     = start_i && ((r_state == IDLE) || w_out_fire);

  // Per-column shift-add: sign-extend the ADC result, weight it by the
  // current bit-plane and subtract on the MSB plane of a signed activation.
  always_comb begin
    w_acc_next = r_acc;
    w_term     = '0;
    for (int c = 0; c < numCols; c++) begin
      w_term = {{(numAccBits-numAdcBits){bus.adc_data_i[c][numAdcBits-1]}},
                bus.adc_data_i[c]} << r_bit_cnt;
      if (w_sub) begin
        w_acc_next[c] = r_acc[c] - w_term;
      end else begin
        w_acc_next[c] = r_acc[c] + w_term;
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_signed  <= 1'b0;
      r_bit_cnt <= '0;
      r_acc     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_n       <= w_n_clamped;
        r_signed  <= cfg_signed_i;
        r_bit_cnt <= '0;
        r_acc     <= '0;
      end else if (w_beat) begin
        r_acc     <= w_acc_next;
        r_bit_cnt <= r_bit_cnt + ONE_N;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_next = ACCUM;
      end
      ACCUM: begin
        if (w_beat && w_last) w_state_next = OUTPUT;
      end
      OUTPUT: begin
        if (w_out_fire) w_state_next = start_i ? ACCUM : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    w_busy      = 1'b0;
    w_adc_ready = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        w_busy      = 1'b1;
        w_adc_ready = 1'b1;
      end
      OUTPUT: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o          = w_busy;
  assign dbg_state_o     = r_state;
  assign bus.adc_ready_o = w_adc_ready;
  assign bus.out_valid_o = w_out_valid;
  // Sums are shown straight from the accumulators; only meaningful with valid.
  assign bus.out_data_o  = r_acc;

endmodule

// File: doc/adc_bitserial_accumulator.md
Name: adc_bitserial_accumulator

Overview:
- Sits directly downstream of the column wrapper's registered, signed ADC outputs (numCols × numAdcBits, two's complement, -8..7).
- Input activations are applied to the array bit-serially, LSB first, one bit-plane per MAC cycle.
- This block shift-adds the per-bit-plane ADC results into full-precision per-column partial sums.
- It presents the sums to the output buffer over a valid/ready handshake.

Parameters:
- numCols, 32, number of array columns / accumulator lanes
- numAdcBits, 4, signed ADC result width per column
- maxInBits, 8, maximum activation precision (bit-planes per MAC)
- numAccBits, numAdcBits+maxInBits, signed accumulator width per column

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous and active-high
- start_i  input  1  begin a new accumulation; config is captured on acceptance
- cfg_n_bits_i  input  $clog2(maxInBits+1)  activation precision, legal 1..maxInBits
- cfg_signed_i  input  1  1 = activation MSB plane has negative weight (two's complement)
- busy_o  output  1  high whenever state != IDLE
- adc_valid_i  input  1  adc_data_i holds one bit-plane result
- adc_ready_o  output  1  high in ACCUM; a beat transfers when valid && ready
- adc_data_i  input  numCols×numAdcBits  signed ADC results, packed [numCols-1:0][numAdcBits-1:0]
- out_valid_o  output  1  out_data_o holds a completed sum
- out_ready_i  input  1  consumer accepts
- out_data_o  output  numCols×numAccBits  signed sums, packed [numCols-1:0][numAccBits-1:0]

Behaviour:
- Reset: synchronous. When rst is high at a clock edge:
  - state <= IDLE
  - all accumulators, bit counter and captured config <= 0
  - busy_o, adc_ready_o, out_valid_o = 0; out_data_o = 0
  - rst overrides all other inputs, including mid-ACCUM and mid-OUTPUT. Any partial sum is discarded and nothing is emitted.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - start_i=1 -> ACCUM next cycle.
  - Capture n = cfg_n_bits_i and signed = cfg_signed_i. cfg_n_bits_i=0 is captured as 1; values > maxInBits are captured as maxInBits.
  - Clear accumulators; bit_cnt <= 0.
  - adc_valid_i is ignored in IDLE.
- ACCUM:
  - adc_ready_o=1. On each transferred beat, for every column c: acc[c] <= acc[c] ± (sext(adc_data_i[c]) << bit_cnt).
  - The sign is negative only when signed=1 and bit_cnt==n-1; otherwise positive.
  - After the beat, bit_cnt <= bit_cnt+1.
  - On the beat where bit_cnt==n-1 -> OUTPUT. out_valid_o rises the cycle after the last beat (latency 1).
  - Cycles without adc_valid_i leave acc and bit_cnt unchanged (bubbles allowed).
  - start_i is ignored.
- Arithmetic: full-precision, no saturation. numAccBits is sized so the worst case never wraps: unsigned n=8 spans -2040..1785; signed spans -1912..1913.
- OUTPUT:
  - out_valid_o=1; out_data_o holds the final acc stable until the handshake.
  - adc_ready_o=0; extra adc_valid_i beats are ignored and are not buffered.
  - out_valid_o && out_ready_i with start_i=0 -> IDLE.
  - Same handshake with start_i=1 -> ACCUM directly, with new config captured and accumulators cleared that cycle (zero-bubble back-to-back).
  - out_valid_o never drops without a handshake, except on rst.
- out_data_o reflects the accumulator register directly. In IDLE it holds the last value (or 0 after reset); consumers must qualify it with out_valid_o.
- n=1 unsigned: a single beat passes sext(adc) through; with signed=1 it outputs -sext(adc).

Test Plan:
- rst, then start_i with n=4, signed=0. col0 beats 1, 2, -1, 3 -> out_valid_o one cycle after the 4th beat, out_data_o[0]=25, busy_o high from the cycle after start until the handshake.
- Same stimulus with signed=1 -> out_data_o[0]=-23. All-columns variant, col c gets constant c%16-8 for n=8 unsigned -> each column = (c%16-8)*255; col0=-2040, col15=1785.
- n=8, signed=1, all beats -8 -> 8 in every column; all beats 7 -> -7. No wrap at 12 bits.
- Bubbles and backpressure:
  - adc_valid_i toggled every other cycle -> same sums as the gapless case.
  - out_ready_i held low for 5 cycles -> out_data_o stable, adc_ready_o=0, extra beats ignored.
  - Then out_ready_i=1 together with start_i=1 -> ACCUM the next cycle with cleared accumulators.
- rst asserted after 2 of 4 beats -> next cycle IDLE, all outputs 0, no out_valid_o. A subsequent start with 4 beats -> a fresh correct sum.
- cfg_n_bits_i=0 -> behaves as n=1 (single beat 5 -> 5). cfg_n_bits_i=15 -> clamped to 8 beats. start_i asserted during ACCUM -> ignored, sum unaffected.
